// File: rtl/bpsk_phase_sequencer_if.sv
// ---------------------------------------------------------------------------
// bpsk_phase_sequencer_if
// Bundles the signals between the framing logic, the BPSK phase sequencer
// and the sine wave table.
//   start, tx_bit, tx_last, tx_valid : framing side -> sequencer
//   tx_ready                         : sequencer -> framing side
//   phase, phase_valid, symbol_strobe,
//   busy, done, underrun             : sequencer status and wave table index
// master = bit source / observer, slave = sequencer.
// ---------------------------------------------------------------------------
interface bpsk_phase_sequencer_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  start;
  logic                  tx_bit;
  logic                  tx_last;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] phase;
  logic                  phase_valid;
  logic                  symbol_strobe;
  logic                  busy;
  logic                  done;
  logic                  underrun;

  modport master (
    output start, tx_bit, tx_last, tx_valid,
    input  tx_ready, phase, phase_valid, symbol_strobe, busy, done, underrun
  );

  modport slave (
    input  start, tx_bit, tx_last, tx_valid,
    output tx_ready, phase, phase_valid, symbol_strobe, busy, done, underrun
  );
endinterface

// File: rtl/bpsk_phase_sequencer.sv
// ---------------------------------------------------------------------------
// bpsk_phase_sequencer
// Produces the sine-table phase index for a BPSK carrier. A phase accumulator
// runs continuously while a frame is active; an alternating 0,1,0,1 preamble
// is sent first, then data bits are pulled over a valid/ready handshake.
// A '1' symbol adds half a carrier period to the table index.
// Ports:
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   bus_if  : slave modport (start, tx_* in; tx_ready, phase, status out)
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | waiting for start, phase held at 0
// S_PREAMBLE | sending alternating preamble symbols
// S_DATA     | sending handshaked data bits
// S_DONE     | single cycle, done pulse visible, then back to idle
// ---------------------------------------------------------------------------
module bpsk_phase_sequencer #(
  parameter int DATA_WIDTH        = 12,
  parameter int SINE_RESOLUTION   = 1024,
  parameter int PHASE_STEP        = 16,
  parameter int CYCLES_PER_SYMBOL = 128,
  parameter int PREAMBLE_SYMBOLS  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bpsk_phase_sequencer_if.slave    bus_if
);

  localparam int PERIOD = 2 * SINE_RESOLUTION;
  localparam int SYM_W  = $clog2(CYCLES_PER_SYMBOL);
  localparam int PRE_W  = (PREAMBLE_SYMBOLS > 1) ? $clog2(PREAMBLE_SYMBOLS) : 1;
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(CYCLES_PER_SYMBOL - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_SYMBOLS - 1);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DONE} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] acc_d;
  logic [SYM_W-1:0]      sym_cnt_q;
  logic [PRE_W-1:0]      pre_cnt_q;
  logic                  cur_bit_q;
  logic                  cur_last_q;
  logic                  done_q;
  logic                  underrun_q;

  logic active;
  logic sym_end;

  // Modulo add in integer arithmetic so a period of exactly 2**DATA_WIDTH
  // still wraps correctly.
  function automatic logic [DATA_WIDTH-1:0] wrap_add(input logic [DATA_WIDTH-1:0] a,
                                                     input int b);
    int s;
    s = int'(a) + b;
    if (s >= PERIOD) s = s - PERIOD;
    return DATA_WIDTH'(s);
  endfunction

  assign active  = (state_q == S_PREAMBLE) || (state_q == S_DATA);
  assign sym_end = active && (sym_cnt_q == SYM_LAST);
  assign acc_d   = wrap_add(acc_q, PHASE_STEP);

  // Ready only at a symbol boundary that needs a new bit: end of the last
  // preamble symbol, or end of a data symbol that was not flagged last.
  assign bus_if.tx_ready = sym_end &&
                           (((state_q == S_PREAMBLE) && (pre_cnt_q == PRE_LAST)) ||
                            ((state_q == S_DATA) && !cur_last_q));

  assign bus_if.phase         = active ? wrap_add(acc_q, cur_bit_q ? SINE_RESOLUTION : 0)
                                       : '0;
  assign bus_if.phase_valid   = active;
  assign bus_if.symbol_strobe = active && (sym_cnt_q == '0);
  assign bus_if.busy          = (state_q != S_IDLE);
  assign bus_if.done          = done_q;
  assign bus_if.underrun      = underrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      sym_cnt_q  <= '0;
      pre_cnt_q  <= '0;
      cur_bit_q  <= 1'b0;
      cur_last_q <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus_if.start) begin
            state_q    <= S_PREAMBLE;
            acc_q      <= '0;
            sym_cnt_q  <= '0;
            pre_cnt_q  <= '0;
            cur_bit_q  <= 1'b0;
            cur_last_q <= 1'b0;
          end
        end
        S_PREAMBLE: begin
          acc_q <= acc_d;
          if (sym_cnt_q != SYM_LAST) begin
            sym_cnt_q <= sym_cnt_q + SYM_W'(1);
          end else if (pre_cnt_q != PRE_LAST) begin
            sym_cnt_q <= '0;
            pre_cnt_q <= pre_cnt_q + PRE_W'(1);
            cur_bit_q <= ~pre_cnt_q[0];      // bit 0 of the incremented count
          end else if (bus_if.tx_valid) begin
            sym_cnt_q  <= '0;
            cur_bit_q  <= bus_if.tx_bit;
            cur_last_q <= bus_if.tx_last;
            state_q    <= S_DATA;
          end else begin
            underrun_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        S_DATA: begin
          acc_q <= acc_d;
          if (sym_cnt_q != SYM_LAST) begin
            sym_cnt_q <= sym_cnt_q + SYM_W'(1);
          end else if (cur_last_q) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (bus_if.tx_valid) begin
            sym_cnt_q  <= '0;
            cur_bit_q  <= bus_if.tx_bit;
            cur_last_q <= bus_if.tx_last;
          end else begin
            underrun_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
